// File: rtl/layer_scheduler.sv
// -----------------------------------------------------------------------------
// layer_scheduler
//
// Multi-layer sequencer for the convolution pipeline. Runs NUM_LAYERS compute
// engines in order: it pulses layer_start to the selected engine, waits for
// layer_done, and then (except after the last layer) streams the (x, y, ch)
// write-index sequence that moves that layer's output into the next layer's
// input memory. A watchdog on the done-wait can push the sequencer into an
// error state. abort returns to idle from any state.
//
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   start        begin a run (sampled in IDLE, DONE and ERROR only)
//   abort        synchronous abort, forces IDLE on the next cycle
//   busy         high in START, WAIT and XFER
//   done         one-cycle pulse when the last layer completes
//   err          watchdog fired; held until the next start, abort or reset
//   layer_sel    index of the active layer
//   layer_start  one-cycle start pulse to the selected engine
//   layer_done   completion strobe from the selected engine (WAIT only)
//   xfer_valid   write index valid toward the next-layer input memory
//   xfer_ready   memory accepts the beat
//   xfer_x/y/ch  column / row / channel write index
//   xfer_last    high with the final beat of a transfer
// -----------------------------------------------------------------------------
module layer_scheduler #(
    parameter int unsigned                   NUM_LAYERS = 3,
    parameter int unsigned                   IDX_W      = 16,
    parameter int unsigned                   LSEL_W     = 4,
    parameter logic [NUM_LAYERS*IDX_W-1:0]   LAYER_DIM  = {16'd0, 16'd13, 16'd26},
    parameter logic [NUM_LAYERS*IDX_W-1:0]   LAYER_CH   = {16'd0, 16'd16, 16'd16},
    parameter int unsigned                   TIMEOUT    = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [LSEL_W-1:0] layer_sel,
    output logic              layer_start,
    input  logic              layer_done,
    output logic              xfer_valid,
    input  logic              xfer_ready,
    output logic [IDX_W-1:0]  xfer_x,
    output logic [IDX_W-1:0]  xfer_y,
    output logic [IDX_W-1:0]  xfer_ch,
    output logic              xfer_last
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_XFER,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [IDX_W-1:0]  ONE        = IDX_W'(1);
    localparam logic [LSEL_W-1:0] LAST_LAYER = LSEL_W'(NUM_LAYERS - 1);
    localparam logic [31:0]       WD_LIMIT   = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [LSEL_W-1:0] sel_q;
    logic [31:0]       wd_q;
    logic [IDX_W-1:0]  x_q, y_q, ch_q;
    logic              last_q;

    // Per-layer dimension tables, padded to the full layer_sel range so the
    // lookup index never needs a width change.
    logic [IDX_W-1:0] dim_tab [2**LSEL_W];
    logic [IDX_W-1:0] ch_tab  [2**LSEL_W];

    genvar g;
    generate
        for (g = 0; g < 2**LSEL_W; g++) begin : g_tab
            if (g < NUM_LAYERS) begin : g_used
                assign dim_tab[g] = LAYER_DIM[g*IDX_W +: IDX_W];
                assign ch_tab[g]  = LAYER_CH[g*IDX_W +: IDX_W];
            end else begin : g_unused
                assign dim_tab[g] = '0;
                assign ch_tab[g]  = '0;
            end
        end
    endgenerate

    logic [IDX_W-1:0] dim_m1, ch_m1;
    logic [IDX_W-1:0] nx, ny, nch;
    logic             x_wrap, y_wrap, nlast, first_last;
    logic             last_layer, wd_expire;

    assign dim_m1     = dim_tab[sel_q] - ONE;
    assign ch_m1      = ch_tab[sel_q] - ONE;
    assign last_layer = (sel_q == LAST_LAYER);
    assign wd_expire  = (TIMEOUT != 0) && (wd_q == WD_LIMIT);

    // Next index triple in x-fastest order, and whether that next beat is
    // the final one. xfer_last is registered alongside the indices, so it is
    // computed from the indices the register is about to take.
    always_comb begin
        x_wrap     = (x_q == dim_m1);
        y_wrap     = (y_q == dim_m1);
        nx         = x_wrap ? '0 : x_q + ONE;
        ny         = x_wrap ? (y_wrap ? '0 : y_q + ONE) : y_q;
        nch        = (x_wrap && y_wrap) ? ch_q + ONE : ch_q;
        nlast      = (nx == dim_m1) && (ny == dim_m1) && (nch == ch_m1);
        // A 1x1x1 transfer is last on its very first beat.
        first_last = (dim_m1 == '0) && (ch_m1 == '0);
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE:  if (start) state_d = S_START;
                S_START: state_d = S_WAIT;
                S_WAIT: begin
                    // layer_done takes priority over a coincident watchdog expiry
                    if (layer_done)     state_d = last_layer ? S_DONE : S_XFER;
                    else if (wd_expire) state_d = S_ERROR;
                end
                S_XFER:  if (xfer_ready && last_q) state_d = S_START;
                S_DONE:  state_d = start ? S_START : S_IDLE;
                S_ERROR: if (start) state_d = S_START;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Datapath registers: layer select, watchdog and transfer indices
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_q  <= '0;
            wd_q   <= '0;
            x_q    <= '0;
            y_q    <= '0;
            ch_q   <= '0;
            last_q <= 1'b0;
        end else if (abort) begin
            sel_q  <= '0;
            wd_q   <= '0;
            x_q    <= '0;
            y_q    <= '0;
            ch_q   <= '0;
            last_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) sel_q <= '0;
                end
                S_START: begin
                    wd_q <= '0;
                end
                S_WAIT: begin
                    wd_q <= wd_q + 32'd1;
                    if (layer_done && !last_layer) begin
                        x_q    <= '0;
                        y_q    <= '0;
                        ch_q   <= '0;
                        last_q <= first_last;
                    end
                end
                S_XFER: begin
                    if (xfer_ready) begin
                        if (last_q) begin
                            sel_q  <= sel_q + LSEL_W'(1);
                            x_q    <= '0;
                            y_q    <= '0;
                            ch_q   <= '0;
                            last_q <= 1'b0;
                        end else begin
                            x_q    <= nx;
                            y_q    <= ny;
                            ch_q   <= nch;
                            last_q <= nlast;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Output decode
    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        layer_start = 1'b0;
        xfer_valid  = 1'b0;
        unique case (state_q)
            S_START: begin
                busy        = 1'b1;
                layer_start = 1'b1;
            end
            S_WAIT:  busy = 1'b1;
            S_XFER: begin
                busy       = 1'b1;
                xfer_valid = 1'b1;
            end
            S_DONE:  done = 1'b1;
            S_ERROR: err  = 1'b1;
            default: ;
        endcase
    end

    assign layer_sel = sel_q;
    assign xfer_x    = x_q;
    assign xfer_y    = y_q;
    assign xfer_ch   = ch_q;
    assign xfer_last = last_q;

endmodule

// File: tb/tb_layer_scheduler.sv
module tb_layer_scheduler;

    localparam int D0     = 3;
    localparam int C0     = 2;
    localparam int NBEATS = D0 * D0 * C0;
    localparam int TO     = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Two-layer instance
    logic        reset_n, start, abort, xfer_ready;
    logic        layer_done = 1'b0;
    logic        busy, done, err, layer_start, xfer_valid, xfer_last;
    logic [3:0]  layer_sel;
    logic [15:0] xfer_x, xfer_y, xfer_ch;

    // Single-layer instance
    logic        start_b, abort_b, xfer_ready_b;
    logic        layer_done_b = 1'b0;
    logic        busy_b, done_b, err_b, layer_start_b, xfer_valid_b, xfer_last_b;
    logic [3:0]  layer_sel_b;
    logic [15:0] xfer_x_b, xfer_y_b, xfer_ch_b;

    layer_scheduler #(
        .NUM_LAYERS (2),
        .IDX_W      (16),
        .LSEL_W     (4),
        .LAYER_DIM  ({16'd0, 16'd3}),
        .LAYER_CH   ({16'd0, 16'd2}),
        .TIMEOUT    (TO)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .busy(busy), .done(done), .err(err), .layer_sel(layer_sel),
        .layer_start(layer_start), .layer_done(layer_done),
        .xfer_valid(xfer_valid), .xfer_ready(xfer_ready),
        .xfer_x(xfer_x), .xfer_y(xfer_y), .xfer_ch(xfer_ch), .xfer_last(xfer_last)
    );

    layer_scheduler #(
        .NUM_LAYERS (1),
        .IDX_W      (16),
        .LSEL_W     (4),
        .LAYER_DIM  (16'd0),
        .LAYER_CH   (16'd0),
        .TIMEOUT    (0)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .abort(abort_b),
        .busy(busy_b), .done(done_b), .err(err_b), .layer_sel(layer_sel_b),
        .layer_start(layer_start_b), .layer_done(layer_done_b),
        .xfer_valid(xfer_valid_b), .xfer_ready(xfer_ready_b),
        .xfer_x(xfer_x_b), .xfer_y(xfer_y_b), .xfer_ch(xfer_ch_b), .xfer_last(xfer_last_b)
    );

    int checks = 0;
    int errors = 0;

    // Engine models: answer layer_done a configurable number of cycles after
    // layer_start; a delay of 0 means the engine never answers.
    int eng_delay [2];
    int eng_cnt = 0;
    always @(negedge clk) begin
        layer_done = 1'b0;
        if (eng_cnt != 0) begin
            eng_cnt = eng_cnt - 1;
            if (eng_cnt == 0) layer_done = 1'b1;
        end
        if (layer_start === 1'b1) eng_cnt = eng_delay[layer_sel[0]];
    end

    int eng_b_delay = 3;
    int eng_b_cnt = 0;
    int eng_b_fire_cyc = 0;
    always @(negedge clk) begin
        layer_done_b = 1'b0;
        if (eng_b_cnt != 0) begin
            eng_b_cnt = eng_b_cnt - 1;
            if (eng_b_cnt == 0) begin
                layer_done_b = 1'b1;
                eng_b_fire_cyc = cyc;
            end
        end
        if (layer_start_b === 1'b1) eng_b_cnt = eng_b_delay;
    end

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] ch;
        logic        last;
    } beat_t;

    beat_t exp_q [$];

    // Reference beat sequence: x fastest, then y, then ch; last on the final beat
    initial begin
        int idx;
        idx = 0;
        for (int c = 0; c < C0; c++)
            for (int y = 0; y < D0; y++)
                for (int x = 0; x < D0; x++) begin
                    exp_q.push_back(beat_t'({16'(x), 16'(y), 16'(c), idx == NBEATS - 1}));
                    idx++;
                end
    end

    // Observation record filled by collect()
    beat_t beats [$];
    int    ls_sel [$];
    int    stall_bad, after_last_bad, done_cnt, done_cyc, last_acc_cyc;
    bit    post_idle_ok, hung;

    // Launch a run on the two-layer instance and record what it does; no
    // judgement here. cut_beat != 0 returns at the negedge where that beat
    // is about to be accepted.
    task automatic collect(input bit rnd_ready, input int cut_beat);
        beat_t held;
        bit    pend;
        bit    was_last_acc;
        int    n;
        beats.delete();
        ls_sel.delete();
        stall_bad = 0; after_last_bad = 0; done_cnt = 0; done_cyc = 0;
        last_acc_cyc = 0; post_idle_ok = 1'b0; hung = 1'b0;
        pend = 1'b0; was_last_acc = 1'b0;
        held = '0;
        @(negedge clk);
        start = 1'b1;
        xfer_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (n = 0; n < 600; n++) begin
            if (was_last_acc) begin
                if (xfer_valid !== 1'b0 || layer_start !== 1'b1) after_last_bad++;
                was_last_acc = 1'b0;
            end
            if (layer_start === 1'b1) ls_sel.push_back(int'(layer_sel));
            if (pend && (xfer_valid !== 1'b1 ||
                         beat_t'({xfer_x, xfer_y, xfer_ch, xfer_last}) !== held)) stall_bad++;
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end else if (done_cnt > 0) begin
                post_idle_ok = (busy === 1'b0) && (xfer_valid === 1'b0);
                break;
            end
            xfer_ready = rnd_ready ? 1'($urandom % 2) : 1'b1;
            // start while busy must be ignored
            start = (rnd_ready && busy === 1'b1 && done !== 1'b1) ? 1'($urandom % 2) : 1'b0;
            pend = 1'b0;
            if (xfer_valid === 1'b1) begin
                if (xfer_ready) begin
                    beats.push_back(beat_t'({xfer_x, xfer_y, xfer_ch, xfer_last}));
                    last_acc_cyc = cyc;
                    if (xfer_last === 1'b1) was_last_acc = 1'b1;
                    if (cut_beat != 0 && beats.size() == cut_beat) begin
                        start = 1'b0;
                        return;
                    end
                end else begin
                    pend = 1'b1;
                    held = beat_t'({xfer_x, xfer_y, xfer_ch, xfer_last});
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        hung = (n >= 600);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        start = 1'b0; abort = 1'b0; xfer_ready = 1'b0;
        start_b = 1'b0; abort_b = 1'b0; xfer_ready_b = 1'b0;
        eng_delay[0] = 4; eng_delay[1] = 4;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, err, layer_sel, layer_start, xfer_valid, xfer_x, xfer_y, xfer_ch, xfer_last} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got busy=%b done=%b err=%b sel=%0d ls=%b v=%b x=%0d y=%0d ch=%0d last=%b exp all 0",
                     busy, done, err, layer_sel, layer_start, xfer_valid, xfer_x, xfer_y, xfer_ch, xfer_last);
        end
        checks++;
        if ({busy_b, done_b, err_b, layer_sel_b, layer_start_b, xfer_valid_b} !== '0) begin
            errors++;
            $display("FAIL reset_outputs_b got busy=%b done=%b err=%b sel=%0d ls=%b v=%b exp all 0",
                     busy_b, done_b, err_b, layer_sel_b, layer_start_b, xfer_valid_b);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_run;
        collect(1'b0, 0);
        checks++;
        if (hung) begin errors++; $display("FAIL basic_hang got no done exp done"); end
        checks++;
        if (ls_sel.size() != 2 || ls_sel[0] != 0 || ls_sel[1] != 1) begin
            errors++;
            $display("FAIL basic_layer_starts got count=%0d exp 2 pulses sel 0,1", ls_sel.size());
        end
        checks++;
        if (beats.size() != NBEATS) begin
            errors++;
            $display("FAIL basic_beat_count got %0d exp %0d", beats.size(), NBEATS);
        end else begin
            for (int i = 0; i < NBEATS; i++) begin
                checks++;
                if (beats[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL basic_beat_%0d got %h exp %h", i, beats[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (after_last_bad != 0) begin
            errors++;
            $display("FAIL basic_after_last got %0d bad cycles exp 0 (valid=0, start pulse)", after_last_bad);
        end
        checks++;
        if (done_cnt != 1 || !post_idle_ok) begin
            errors++;
            $display("FAIL basic_done got done_cycles=%0d idle_after=%b exp 1 and 1", done_cnt, post_idle_ok);
        end
    endtask

    task automatic test_backpressure;
        for (int r = 0; r < 3; r++) begin
            collect(1'b1, 0);
            checks++;
            if (hung || beats.size() != NBEATS) begin
                errors++;
                $display("FAIL bp_beat_count run %0d got %0d hung=%b exp %0d", r, beats.size(), hung, NBEATS);
            end else begin
                for (int i = 0; i < NBEATS; i++) begin
                    checks++;
                    if (beats[i] !== exp_q[i]) begin
                        errors++;
                        $display("FAIL bp_beat_%0d run %0d got %h exp %h", i, r, beats[i], exp_q[i]);
                    end
                end
            end
            checks++;
            if (stall_bad != 0) begin
                errors++;
                $display("FAIL bp_stall_hold run %0d got %0d unstable stalls exp 0", r, stall_bad);
            end
            checks++;
            if (ls_sel.size() != 2 || done_cnt != 1 || done_cyc <= last_acc_cyc) begin
                errors++;
                $display("FAIL bp_done run %0d got starts=%0d done=%0d done_cyc=%0d last_cyc=%0d exp 2,1,done after last",
                         r, ls_sel.size(), done_cnt, done_cyc, last_acc_cyc);
            end
        end
    endtask

    task automatic wait_layer_start(input int sel, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (layer_start === 1'b1 && layer_sel === 4'(sel)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_timeout;
        bit ok;
        bit bad;
        eng_delay[0] = 4; eng_delay[1] = 0;
        xfer_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_layer_start(1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL to_reach_layer1 got no start for layer 1 exp start"); end
        bad = 1'b0;
        for (int k = 1; k <= TO; k++) begin
            @(negedge clk);
            if (busy !== 1'b1 || err !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL to_wait_window got early exit from WAIT exp %0d busy cycles", TO); end
        @(negedge clk);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || layer_sel !== 4'd1) begin
            errors++;
            $display("FAIL to_error got err=%b busy=%b sel=%0d exp err=1 busy=0 sel=1", err, busy, layer_sel);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL to_err_hold got %b exp 1", err); end
        eng_delay[1] = 4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (layer_start !== 1'b1 || layer_sel !== 4'd0 || err !== 1'b0) begin
            errors++;
            $display("FAIL to_restart got ls=%b sel=%0d err=%b exp 1,0,0", layer_start, layer_sel, err);
        end
        wait_done(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL to_restart_done got no done exp done"); end
        @(negedge clk);
    endtask

    task automatic test_done_at_timeout;
        bit ok;
        eng_delay[0] = TO; eng_delay[1] = 4;
        xfer_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (layer_start !== 1'b1 || layer_sel !== 4'd0) begin
            errors++;
            $display("FAIL coincide_start got ls=%b sel=%0d exp 1,0", layer_start, layer_sel);
        end
        repeat (TO + 1) @(negedge clk);
        checks++;
        if (xfer_valid !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL coincide_xfer got valid=%b err=%b exp valid=1 err=0", xfer_valid, err);
        end
        wait_done(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL coincide_done got no done exp done"); end
        @(negedge clk);
        eng_delay[0] = 4;
    endtask

    task automatic test_abort;
        collect(1'b0, 7);
        abort = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, err, layer_sel, layer_start, xfer_valid, xfer_x, xfer_y, xfer_ch, xfer_last} !== '0) begin
            errors++;
            $display("FAIL abort_outputs got busy=%b sel=%0d v=%b x=%0d y=%0d ch=%0d last=%b exp all 0",
                     busy, layer_sel, xfer_valid, xfer_x, xfer_y, xfer_ch, xfer_last);
        end
        abort = 1'b0;
        collect(1'b0, 0);
        checks++;
        if (hung || beats.size() != NBEATS || done_cnt != 1) begin
            errors++;
            $display("FAIL abort_rerun got beats=%0d done=%0d hung=%b exp %0d,1,0", beats.size(), done_cnt, hung, NBEATS);
        end else begin
            for (int i = 0; i < NBEATS; i++) begin
                checks++;
                if (beats[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL abort_rerun_beat_%0d got %h exp %h", i, beats[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        collect(1'b0, 7);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, err, layer_sel, layer_start, xfer_valid, xfer_x, xfer_y, xfer_ch, xfer_last} !== '0) begin
            errors++;
            $display("FAIL rst_mid_outputs got busy=%b sel=%0d v=%b x=%0d y=%0d ch=%0d last=%b exp all 0",
                     busy, layer_sel, xfer_valid, xfer_x, xfer_y, xfer_ch, xfer_last);
        end
        @(negedge clk);
        reset_n = 1'b1;
        collect(1'b0, 0);
        checks++;
        if (hung || beats.size() != NBEATS || done_cnt != 1 || ls_sel.size() != 2) begin
            errors++;
            $display("FAIL rst_mid_rerun got beats=%0d done=%0d starts=%0d exp %0d,1,2",
                     beats.size(), done_cnt, ls_sel.size(), NBEATS);
        end else begin
            checks++;
            if (beats[NBEATS-1] !== exp_q[NBEATS-1] || beats[0] !== exp_q[0]) begin
                errors++;
                $display("FAIL rst_mid_rerun_ends got %h..%h exp %h..%h",
                         beats[0], beats[NBEATS-1], exp_q[0], exp_q[NBEATS-1]);
            end
        end
    endtask

    task automatic test_single_layer;
        int  starts;
        int  dones;
        bit  any_valid;
        bit  b2b_ok;
        bit  lat_bad;
        starts = 0; dones = 0; any_valid = 1'b0; b2b_ok = 1'b0; lat_bad = 1'b0;
        xfer_ready_b = 1'b1;
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (int n = 0; n < 100 && dones < 2; n++) begin
            if (layer_start_b === 1'b1) starts++;
            if (xfer_valid_b !== 1'b0) any_valid = 1'b1;
            if (start_b) begin
                start_b = 1'b0;
                b2b_ok = (layer_start_b === 1'b1);
            end
            if (done_b === 1'b1) begin
                dones++;
                if (cyc - eng_b_fire_cyc != 1) lat_bad = 1'b1;
                checks++;
                if (starts != dones) begin
                    errors++;
                    $display("FAIL single_starts got %0d starts exp %0d", starts, dones);
                end
                if (dones == 1) start_b = 1'b1;
            end
            @(negedge clk);
        end
        start_b = 1'b0;
        checks++;
        if (dones != 2) begin errors++; $display("FAIL single_done_count got %0d exp 2", dones); end
        checks++;
        if (any_valid) begin errors++; $display("FAIL single_no_xfer got xfer_valid=1 exp never"); end
        checks++;
        if (lat_bad) begin errors++; $display("FAIL single_done_latency got not 1 cycle exp 1"); end
        checks++;
        if (!b2b_ok) begin errors++; $display("FAIL single_back_to_back got ls=0 after done-cycle start exp 1"); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout got no finish exp finish");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_basic_run;
        test_backpressure;
        test_timeout;
        test_done_at_timeout;
        test_abort;
        test_reset_mid;
        test_single_layer;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
